mem_arbiter: RTL and testbench

//  Sequences the shared 2^ADDR_WIDTH x DATA_WIDTH memory between two requesters:

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates a shared single-port synchronous memory between instruction fetch (read-only)
// and load/store (read/write), hiding the memory's registered read latency behind req/gnt/done.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 16,
    parameter bit          RR_EN      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_done,
    output logic [DATA_WIDTH-1:0] if_rdata,

    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_done,
    output logic [DATA_WIDTH-1:0] ls_rdata,

    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic                  mem_output_enable,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic                  last_ls_q;
    logic                  owner_ls_q;
    logic                  op_we_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  if_win;
    logic                  ls_win;
    logic                  grant;
    logic                  grant_we;

    logic                  mem_we_d;
    logic                  mem_oe_d;
    logic                  if_done_d;
    logic                  ls_done_d;

    // The bus is driven only while the registered write strobe is high.
    assign mem_data = mem_write_enable ? wdata_q : {DATA_WIDTH{1'bz}};

    // Tie-break: round-robin favours whoever was not granted last, otherwise LS wins.
    always_comb begin
        if_win = if_req;
        ls_win = ls_req;
        if (if_req && ls_req) begin
            if (RR_EN && last_ls_q) begin
                ls_win = 1'b0;
            end else begin
                if_win = 1'b0;
            end
        end
        if_gnt   = rst_n & (state_q == S_IDLE) & if_win;
        ls_gnt   = rst_n & (state_q == S_IDLE) & ls_win;
        grant    = if_gnt | ls_gnt;
        grant_we = ls_gnt & ls_we;
    end

    // Next state plus next values of the registered strobes.
    always_comb begin
        state_d   = state_q;
        mem_we_d  = 1'b0;
        mem_oe_d  = 1'b0;
        if_done_d = 1'b0;
        ls_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d  = S_ACCESS;
                    mem_we_d = grant_we;
                    mem_oe_d = ~grant_we;
                end
            end
            S_ACCESS: begin
                if (op_we_q) begin
                    state_d   = S_DONE;
                    if_done_d = ~owner_ls_q;
                    ls_done_d = owner_ls_q;
                end else begin
                    state_d  = S_CAPTURE;
                    mem_oe_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d   = S_DONE;
                if_done_d = ~owner_ls_q;
                ls_done_d = owner_ls_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            last_ls_q         <= 1'b1;
            owner_ls_q        <= 1'b0;
            op_we_q           <= 1'b0;
            wdata_q           <= '0;
            mem_address       <= '0;
            mem_write_enable  <= 1'b0;
            mem_output_enable <= 1'b0;
            if_done           <= 1'b0;
            ls_done           <= 1'b0;
            if_rdata          <= '0;
            ls_rdata          <= '0;
            busy              <= 1'b0;
        end else begin
            state_q           <= state_d;
            mem_write_enable  <= mem_we_d;
            mem_output_enable <= mem_oe_d;
            if_done           <= if_done_d;
            ls_done           <= ls_done_d;
            busy              <= (state_d != S_IDLE);
            if (grant) begin
                last_ls_q   <= ls_gnt;
                owner_ls_q  <= ls_gnt;
                op_we_q     <= grant_we;
                mem_address <= ls_gnt ? ls_addr : if_addr;
                wdata_q     <= ls_wdata;
            end
            // Memory presents read data during CAPTURE; latch it for the owning port.
            if (state_q == S_CAPTURE) begin
                if (owner_ls_q) begin
                    ls_rdata <= mem_data;
                end else begin
                    if_rdata <= mem_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: synchronous memory model on the bus, reference word array and
// grant-order model, directed sequence with random addresses and data.
module tb_mem_arbiter;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_done;
    logic [DW-1:0] ls_rdata;
    logic          busy;
    logic [AW-1:0] mem_address;
    logic          mem_write_enable;
    logic          mem_output_enable;
    wire  [DW-1:0] mem_data;

    logic          fp_if_req;
    logic [AW-1:0] fp_if_addr;
    logic          fp_if_gnt;
    logic          fp_if_done;
    logic [DW-1:0] fp_if_rdata;
    logic          fp_ls_req;
    logic          fp_ls_we;
    logic [AW-1:0] fp_ls_addr;
    logic [DW-1:0] fp_ls_wdata;
    logic          fp_ls_gnt;
    logic          fp_ls_done;
    logic [DW-1:0] fp_ls_rdata;
    logic          fp_busy;
    logic [AW-1:0] fp_mem_address;
    logic          fp_mem_we;
    logic          fp_mem_oe;
    wire  [DW-1:0] fp_mem_data;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc   = 0;
    bit            chk_en = 1'b0;

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_if_rd;
    logic [DW-1:0] exp_ls_rd;
    bit            ref_last_ls;

    // Memory model: write on clock, read registered one cycle after the address
    logic [DW-1:0] mem_arr [DEPTH];
    logic [DW-1:0] rd_q  = '0;
    logic          drv_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_write_enable) mem_arr[mem_address] <= mem_data;
        if (mem_output_enable && !mem_write_enable) rd_q <= mem_arr[mem_address];
        drv_q <= mem_output_enable && !mem_write_enable;
    end
    assign mem_data = (drv_q && mem_output_enable) ? rd_q : {DW{1'bz}};

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .busy(busy), .mem_address(mem_address), .mem_write_enable(mem_write_enable),
        .mem_output_enable(mem_output_enable), .mem_data(mem_data)
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .if_req(fp_if_req), .if_addr(fp_if_addr), .if_gnt(fp_if_gnt), .if_done(fp_if_done),
        .if_rdata(fp_if_rdata),
        .ls_req(fp_ls_req), .ls_we(fp_ls_we), .ls_addr(fp_ls_addr), .ls_wdata(fp_ls_wdata),
        .ls_gnt(fp_ls_gnt), .ls_done(fp_ls_done), .ls_rdata(fp_ls_rdata),
        .busy(fp_busy), .mem_address(fp_mem_address), .mem_write_enable(fp_mem_we),
        .mem_output_enable(fp_mem_oe), .mem_data(fp_mem_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Bus exclusivity and single-grant rules hold on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("we_oe_exclusive", 32'(mem_write_enable & mem_output_enable), 0);
            check("fp_we_oe_exclusive", 32'(fp_mem_we & fp_mem_oe), 0);
            check("gnt_onehot", 32'(if_gnt & ls_gnt), 0);
        end
    end

    task automatic wait_gnt(input bit is_ls, output bit got, output int n);
        got = 1'b0;
        n   = 0;
        for (int w = 0; w < 10 && !got; w++) begin
            @(negedge clk);
            if (is_ls ? ls_gnt : if_gnt) begin
                got = 1'b1;
                n   = cyc;
            end
        end
        check("gnt_timeout", 32'(got), 1);
    endtask

    // One complete transaction on the RR instance with latency and data checks.
    task automatic run_op(input bit is_ls, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd);
        bit got;
        bit seen;
        int n;
        int lat;
        @(posedge clk); #1;
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        wait_gnt(is_ls, got, n);
        @(posedge clk); #1;
        if_req   = 1'b0;
        ls_req   = 1'b0;
        ls_we    = ~we;
        ls_addr  = AW'($urandom);
        ls_wdata = DW'($urandom);
        if_addr  = AW'($urandom);
        if (!got) return;
        @(negedge clk);
        check("access_busy", 32'(busy), 1);
        check("access_addr", 32'(mem_address), 32'(a));
        check("access_we", 32'(mem_write_enable), 32'(we));
        check("access_oe", 32'(mem_output_enable), 32'(!we));
        if (we) check("access_wdata", 32'(mem_data), 32'(wd));
        lat  = we ? 2 : 3;
        seen = 1'b0;
        for (int k = 2; k <= 6 && !seen; k++) begin
            @(negedge clk);
            if (is_ls ? ls_done : if_done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 1);
        check("done_latency", 32'(cyc - n), 32'(lat));
        check("other_done_quiet", 32'(is_ls ? if_done : ls_done), 0);
        if (we) begin
            ref_mem[a] = wd;
        end else if (is_ls) begin
            exp_ls_rd = ref_mem[a];
        end else begin
            exp_if_rd = ref_mem[a];
        end
        check("ls_rdata", 32'(ls_rdata), 32'(exp_ls_rd));
        check("if_rdata", 32'(if_rdata), 32'(exp_if_rd));
        ref_last_ls = is_ls;
        @(negedge clk);
        check("idle_after_done", 32'(busy), 0);
    endtask

    initial begin
        bit            got;
        bit            exp_ls;
        int            n;
        int            grants;
        int            dones;
        logic [AW-1:0] a6;
        logic [AW-1:0] a7;
        logic [DW-1:0] wd7;
        logic [AW-1:0] pend_if_a;
        logic [AW-1:0] pend_ls_a;

        rst_n = 1'b0;
        if_req = 1'b1; if_addr = '0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        fp_if_req = 1'b1; fp_if_addr = '0;
        fp_ls_req = 1'b1; fp_ls_we = 1'b0; fp_ls_addr = '0; fp_ls_wdata = '0;
        pend_if_a = '0;
        pend_ls_a = '0;

        // Reset held with both requests high
        @(negedge clk);
        check("rst_if_gnt", 32'(if_gnt), 0);
        check("rst_ls_gnt", 32'(ls_gnt), 0);
        @(negedge clk);
        check("rst_if_gnt2", 32'(if_gnt), 0);
        check("rst_ls_gnt2", 32'(ls_gnt), 0);
        check("rst_fp_gnt", 32'(fp_if_gnt | fp_ls_gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_we", 32'(mem_write_enable), 0);
        check("rst_oe", 32'(mem_output_enable), 0);
        check("rst_addr", 32'(mem_address), 0);
        check("rst_done", 32'(if_done | ls_done), 0);
        check("rst_if_rdata", 32'(if_rdata), 0);
        check("rst_ls_rdata", 32'(ls_rdata), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        if_req = 1'b0; ls_req = 1'b0; fp_if_req = 1'b0; fp_ls_req = 1'b0;
        chk_en = 1'b1;
        exp_if_rd = '0;
        exp_ls_rd = '0;
        ref_last_ls = 1'b1;

        // Top and bottom address write/read
        run_op(1'b1, 1'b1, 11'h7FF, 16'hBEEF);
        run_op(1'b1, 1'b0, 11'h7FF, 16'h0000);
        run_op(1'b1, 1'b1, 11'h000, 16'h1234);
        run_op(1'b0, 1'b0, 11'h000, 16'h0000);

        // Fill the whole memory via LS, read it all back via IF
        for (int a = 0; a < int'(DEPTH); a++) run_op(1'b1, 1'b1, AW'(a), DW'($urandom));
        for (int a = 0; a < int'(DEPTH); a++) run_op(1'b0, 1'b0, AW'(a), '0);

        // Reset during CAPTURE of an IF read drops the done pulse
        a6 = AW'($urandom);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a6;
        wait_gnt(1'b0, got, n);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("capture_oe", 32'(mem_output_enable), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_done", 32'(if_done), 0);
        check("abort_idle", 32'(busy), 0);
        check("abort_oe", 32'(mem_output_enable), 0);
        check("abort_if_rdata", 32'(if_rdata), 0);
        exp_if_rd = '0;
        exp_ls_rd = '0;
        ref_last_ls = 1'b1;
        run_op(1'b0, 1'b0, a6, '0);

        // Reset on the ACCESS edge of a write still commits the write
        a7  = AW'($urandom);
        wd7 = DW'($urandom);
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = a7; ls_wdata = wd7;
        wait_gnt(1'b1, got, n);
        @(posedge clk); #1;
        ls_req = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        check("rstwr_we", 32'(mem_write_enable), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstwr_idle", 32'(busy), 0);
        check("rstwr_no_done", 32'(ls_done), 0);
        ref_mem[a7] = wd7;
        exp_if_rd = '0;
        exp_ls_rd = '0;
        ref_last_ls = 1'b1;

        // Round-robin: both held high, grants alternate, IF first after reset
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = AW'($urandom);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = AW'($urandom);
        grants = 0;
        dones  = 0;
        for (int c = 0; c < 80 && dones < 8; c++) begin
            @(negedge clk);
            if (if_done) begin
                check("rr_if_rdata", 32'(if_rdata), 32'(ref_mem[pend_if_a]));
                dones++;
            end
            if (ls_done) begin
                check("rr_ls_rdata", 32'(ls_rdata), 32'(ref_mem[pend_ls_a]));
                dones++;
            end
            if (if_gnt || ls_gnt) begin
                exp_ls = !ref_last_ls;
                check("rr_ls_gnt", 32'(ls_gnt), 32'(exp_ls));
                check("rr_if_gnt", 32'(if_gnt), 32'(!exp_ls));
                ref_last_ls = exp_ls;
                if (exp_ls) pend_ls_a = ls_addr;
                else        pend_if_a = if_addr;
                grants++;
                @(posedge clk); #1;
                if (grants == 8) begin
                    if_req = 1'b0;
                    ls_req = 1'b0;
                end
                if (exp_ls) ls_addr = AW'($urandom);
                else        if_addr = AW'($urandom);
            end
        end
        check("rr_grants", 32'(grants), 8);
        check("rr_dones", 32'(dones), 8);
        exp_if_rd = ref_mem[pend_if_a];
        exp_ls_rd = ref_mem[pend_ls_a];

        run_op(1'b0, 1'b0, a7, '0);

        // Fixed priority: LS takes every slot until it drops its request
        @(posedge clk); #1;
        fp_if_req = 1'b1; fp_if_addr = AW'($urandom);
        fp_ls_req = 1'b1; fp_ls_we = 1'b0; fp_ls_addr = AW'($urandom);
        grants = 0;
        n      = 0;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            @(negedge clk);
            check("fp_if_blocked", 32'(fp_if_gnt), 0);
            if (fp_ls_gnt) begin
                grants++;
                n = cyc;
                if (grants == 4) begin
                    @(posedge clk); #1;
                    fp_ls_req = 1'b0;
                end
            end
        end
        check("fp_ls_grants", 32'(grants), 4);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (fp_if_gnt) got = 1'b1;
            else check("fp_ls_no_regrant", 32'(fp_ls_gnt), 0);
        end
        check("fp_if_after_drop", 32'(got), 1);
        check("fp_if_slot", 32'(cyc - n), 4);
        @(posedge clk); #1;
        fp_if_req = 1'b0;

        repeat (6) @(posedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
